// File: rtl/button_debounce_pkg.sv
// Shared types and helpers for the push-button conditioning logic.
package debounce_pkg;

    typedef enum logic [1:0] {
        RELEASED,
        WAIT_PRESS,
        PRESSED,
        WAIT_RELEASE
    } state_t;

    function automatic int unsigned ms_to_ticks(input int unsigned clk_freq, input int unsigned ms);
        return clk_freq / 1000 * ms;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer with synchronous reset, for any asynchronous board input.
module sync_2ff (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic s1;

    always_ff @(posedge clk) begin
        if (reset) begin
            s1 <= 1'b0;
            q  <= 1'b0;
        end else begin
            s1 <= d;
            q  <= s1;
        end
    end

endmodule

// File: rtl/button_debounce.sv
// Debounces a raw push-button into a clean level plus press, release and long-press pulses.
module button_debounce
    import debounce_pkg::*;
#(
    parameter int unsigned CLK_FREQ      = 100_000_000,
    parameter int unsigned DEBOUNCE_MS   = 10,
    parameter int unsigned LONG_PRESS_MS = 1000
) (
    input  logic clk,
    input  logic reset,
    input  logic btn_in,
    output logic level,
    output logic press,
    // "release" is a reserved word, hence the suffix
    output logic release_pulse,
    output logic long_press
);

    localparam int unsigned DB_TICKS = ms_to_ticks(CLK_FREQ, DEBOUNCE_MS);
    localparam int unsigned LP_TICKS = ms_to_ticks(CLK_FREQ, LONG_PRESS_MS);
    localparam int unsigned DB_W     = $clog2(DB_TICKS + 1);
    localparam int unsigned LP_W     = $clog2(LP_TICKS + 1);
    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DB_TICKS - 1);
    localparam logic [LP_W-1:0] LP_LAST = LP_W'(LP_TICKS - 1);

    if (CLK_FREQ % 1000 != 0) begin : g_bad_clk_freq
        $error("CLK_FREQ must be a multiple of 1000");
    end
    if (DB_TICKS < 1) begin : g_bad_db_ticks
        $error("debounce window must be at least one clock");
    end
    if (LP_TICKS <= DB_TICKS) begin : g_bad_lp_ticks
        $error("long-press time must exceed the debounce window");
    end

    logic            s2;
    state_t          state;
    logic [DB_W-1:0] db_cnt;
    logic [LP_W-1:0] lp_cnt;
    logic            lp_done;
    logic            release_now;

    sync_2ff u_sync (
        .clk   (clk),
        .reset (reset),
        .d     (btn_in),
        .q     (s2)
    );

    // A confirmed release on the same edge as the long-press deadline suppresses the long press.
    assign release_now = (state == WAIT_RELEASE) && !s2 && (db_cnt == DB_LAST);

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= RELEASED;
            db_cnt        <= '0;
            lp_cnt        <= '0;
            lp_done       <= 1'b0;
            level         <= 1'b0;
            press         <= 1'b0;
            release_pulse <= 1'b0;
            long_press    <= 1'b0;
        end else begin
            press         <= 1'b0;
            release_pulse <= 1'b0;
            long_press    <= 1'b0;

            if ((state == PRESSED || state == WAIT_RELEASE) && !release_now && !lp_done) begin
                if (lp_cnt == LP_LAST) begin
                    long_press <= 1'b1;
                    lp_done    <= 1'b1;
                end else begin
                    lp_cnt <= lp_cnt + 1'b1;
                end
            end

            case (state)
                RELEASED: begin
                    if (s2) begin
                        state  <= WAIT_PRESS;
                        db_cnt <= '0;
                    end
                end
                WAIT_PRESS: begin
                    if (!s2) begin
                        state  <= RELEASED;
                        db_cnt <= '0;
                    end else if (db_cnt == DB_LAST) begin
                        state   <= PRESSED;
                        db_cnt  <= '0;
                        level   <= 1'b1;
                        press   <= 1'b1;
                        lp_cnt  <= '0;
                        lp_done <= 1'b0;
                    end else begin
                        db_cnt <= db_cnt + 1'b1;
                    end
                end
                PRESSED: begin
                    if (!s2) begin
                        state  <= WAIT_RELEASE;
                        db_cnt <= '0;
                    end
                end
                WAIT_RELEASE: begin
                    if (s2) begin
                        state  <= PRESSED;
                        db_cnt <= '0;
                    end else if (release_now) begin
                        state         <= RELEASED;
                        db_cnt        <= '0;
                        level         <= 1'b0;
                        release_pulse <= 1'b1;
                        lp_cnt        <= '0;
                        lp_done       <= 1'b0;
                    end else begin
                        db_cnt <= db_cnt + 1'b1;
                    end
                end
                default: begin
                    state  <= RELEASED;
                    db_cnt <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_button_debounce.sv
// Self-checking bench: directed scenarios plus random stimulus against a run-length reference model.
module tb_button_debounce;

    localparam int DB = 10;
    localparam int LP = 50;

    logic clk = 1'b0;
    logic reset;
    logic btn_in;
    logic level, press, release_pulse, long_press;

    always #5 clk = ~clk;

    button_debounce #(
        .CLK_FREQ      (10_000),
        .DEBOUNCE_MS   (1),
        .LONG_PRESS_MS (5)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .btn_in        (btn_in),
        .level         (level),
        .press         (press),
        .release_pulse (release_pulse),
        .long_press    (long_press)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: synchronizer as a two-sample delay, debounce as a run length of
    // samples disagreeing with the current level, long press as elapsed edges since press.
    logic h1 = 1'b0, h2 = 1'b0;
    logic m_level = 1'b0, m_press = 1'b0, m_release = 1'b0, m_long = 1'b0;
    int   run = 0, since = 0;
    bit   lp_fired = 1'b0;

    int edge_cnt = 0;
    int n_press = 0, n_release = 0, n_long = 0;
    int press_edge = 0, release_edge = 0, long_edge = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s at edge %0d: got %0d, expected %0d", tag, edge_cnt, got, exp);
        end
    endtask

    task automatic model_edge(input logic b, input logic r);
        logic seen;
        m_press = 1'b0;
        m_release = 1'b0;
        m_long = 1'b0;
        if (r) begin
            h1 = 1'b0;
            h2 = 1'b0;
            m_level = 1'b0;
            run = 0;
            since = 0;
            lp_fired = 1'b0;
        end else begin
            seen = h2;
            h2 = h1;
            h1 = b;
            if (seen != m_level) run++;
            else run = 0;
            if (run == DB + 1) begin
                m_level = ~m_level;
                run = 0;
                if (m_level) begin
                    m_press = 1'b1;
                    since = 0;
                    lp_fired = 1'b0;
                end else begin
                    m_release = 1'b1;
                end
            end else if (m_level) begin
                since++;
                if (since == LP && !lp_fired) begin
                    m_long = 1'b1;
                    lp_fired = 1'b1;
                end
            end
        end
    endtask

    task automatic step(input logic b, input logic r);
        @(negedge clk);
        btn_in = b;
        reset = r;
        @(posedge clk);
        edge_cnt++;
        model_edge(b, r);
        #1;
        check("level", 32'(level), 32'(m_level));
        check("press", 32'(press), 32'(m_press));
        check("release", 32'(release_pulse), 32'(m_release));
        check("long_press", 32'(long_press), 32'(m_long));
        if (press) begin n_press++; press_edge = edge_cnt; end
        if (release_pulse) begin n_release++; release_edge = edge_cnt; end
        if (long_press) begin n_long++; long_edge = edge_cnt; end
    endtask

    task automatic hold(input logic b, input int cycles);
        for (int i = 0; i < cycles; i++) step(b, 1'b0);
    endtask

    task automatic clear_counts();
        n_press = 0;
        n_release = 0;
        n_long = 0;
    endtask

    int start_edge;

    initial begin
        btn_in = 1'b0;
        reset = 1'b1;
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1);
        check("reset_level", 32'(level), 0);
        hold(1'b0, 5);

        // 1: clean press and release
        clear_counts();
        start_edge = edge_cnt + 1;
        hold(1'b1, 20);
        check("s1_press_latency", 32'(press_edge - start_edge), 12);
        check("s1_level_held", 32'(level), 1);
        start_edge = edge_cnt + 1;
        hold(1'b0, 20);
        check("s1_release_latency", 32'(release_edge - start_edge), 12);
        check("s1_counts", 32'(n_press * 100 + n_release * 10 + n_long), 110);

        // 2: sustained bounce, period 6
        clear_counts();
        for (int i = 0; i < 40; i++) step((i % 6) < 3, 1'b0);
        hold(1'b0, 20);
        check("s2_no_pulses", 32'(n_press + n_release + n_long), 0);
        check("s2_level", 32'(level), 0);

        // 3: long hold
        clear_counts();
        hold(1'b1, 100);
        hold(1'b0, 20);
        check("s3_long_delay", 32'(long_edge - press_edge), LP);
        check("s3_counts", 32'(n_press * 100 + n_release * 10 + n_long), 111);

        // 4: short low glitches during a hold
        clear_counts();
        hold(1'b1, 20);
        hold(1'b0, 4);
        hold(1'b1, 16);
        hold(1'b0, 4);
        hold(1'b1, 56);
        check("s4_no_release", 32'(n_release), 0);
        check("s4_long_delay", 32'(long_edge - press_edge), LP);
        hold(1'b0, 20);
        check("s4_counts", 32'(n_press * 100 + n_release * 10 + n_long), 111);

        // 5: reset pulse while pressed
        clear_counts();
        hold(1'b1, 30);
        step(1'b1, 1'b1);
        check("s5_reset_level", 32'(level), 0);
        start_edge = edge_cnt + 1;
        hold(1'b1, 30);
        check("s5_repress_latency", 32'(press_edge - start_edge), 12);
        check("s5_no_release", 32'(n_release), 0);
        hold(1'b0, 20);

        // 6: early release, then a fresh long hold
        clear_counts();
        hold(1'b1, 30);
        hold(1'b0, 20);
        check("s6_short_counts", 32'(n_press * 100 + n_release * 10 + n_long), 110);
        clear_counts();
        hold(1'b1, 80);
        hold(1'b0, 20);
        check("s6_long_delay", 32'(long_edge - press_edge), LP);
        check("s6_long_counts", 32'(n_press * 100 + n_release * 10 + n_long), 111);

        // random runs of random length, with occasional reset
        for (int blk = 0; blk < 250; blk++) begin
            logic b;
            int len;
            b = 1'($urandom_range(0, 1));
            len = (($urandom & 3) == 0) ? int'($urandom_range(40, 70)) : int'($urandom_range(1, 15));
            if ($urandom_range(0, 60) == 0) step(b, 1'b1);
            hold(b, len);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/button_debounce.md
# button_debounce

Input-side counterpart to the LED drivers: conditions a raw, asynchronous, bouncing push-button into a clean synchronous level plus single-cycle press, release and long-press events. It sits between a board button pin and any control logic, such as mode toggles or blink-rate selection. It uses one clock domain and a tick counter derived from the clock frequency.

## Interface
- `CLK_FREQ`, 100_000_000: clock frequency in Hz. Must be a multiple of 1000.
- `DEBOUNCE_MS`, 10: stability window in ms. `DB_TICKS = CLK_FREQ/1000*DEBOUNCE_MS`, must be ≥ 1.
- `LONG_PRESS_MS`, 1000: hold time for the long-press event. `LP_TICKS = CLK_FREQ/1000*LONG_PRESS_MS`, must be > `DB_TICKS`.
- `clk` in 1: single clock; all logic is on the rising edge.
- `reset` in 1: synchronous, active-high reset.
- `btn_in` in 1: raw button, asynchronous, active-high, may bounce.
- `level` out 1: debounced button state.
- `press` out 1: one-cycle pulse on a debounced 0→1 transition.
- `release` out 1: one-cycle pulse on a debounced 1→0 transition.
- `long_press` out 1: one-cycle pulse, at most once per press, after `LP_TICKS` cycles in the held state.

## Operation
- 2-flop synchronizer: `btn_in` → `s1` → `s2`, both reset to 0. The FSM sees only `s2`.
- Debounce counter `db_cnt`, width `$clog2(DB_TICKS+1)`. It is cleared on every FSM state change.
- FSM states:
  - RELEASED (reset state, `level`=0): `s2`=1 → WAIT_PRESS.
  - WAIT_PRESS:
    - `s2`=0 → RELEASED; this is a bounce, with no pulse.
    - else if `db_cnt`==`DB_TICKS`-1 → PRESSED and assert `press`.
    - else `db_cnt`++.
  - PRESSED (`level`=1): `s2`=0 → WAIT_RELEASE.
  - WAIT_RELEASE (`level` stays 1):
    - `s2`=1 → PRESSED; this is a bounce, with no pulse.
    - else if `db_cnt`==`DB_TICKS`-1 → RELEASED and assert `release`.
    - else `db_cnt`++.
- Long-press counter `lp_cnt`, width `$clog2(LP_TICKS+1)`, plus flag `lp_done`:
  - Cleared on entry to PRESSED from WAIT_PRESS.
  - Increments every cycle in PRESSED or WAIT_RELEASE; it is not reset by release-bounce.
  - When `lp_cnt`==`LP_TICKS`-1 and `lp_done`=0: assert `long_press` and set `lp_done`. `lp_cnt` saturates from then on.
  - `lp_done` and `lp_cnt` are cleared on entry to RELEASED.
- Rules:
  - `press` and `release` are never asserted in the same cycle.
  - `long_press` may coincide with no other pulse except when `LP_TICKS` aligns with a release-bounce return. That is legal; each event fires at most once.
  - Release confirmed before `LP_TICKS`: no `long_press` for that press.

## Timing
- All outputs are registered. Reset values: `level`=0, `press`=0, `release`=0, `long_press`=0, state RELEASED, counters 0.
- Press latency: `btn_in` rises cleanly before edge k and stays high. Then `level` and `press` go high after edge k+2+`DB_TICKS` (3 edges for sync and state entry, then `DB_TICKS` counting edges). `press` is high for exactly one cycle.
- Release latency is symmetric: `DB_TICKS`+3 edges from a clean `btn_in` fall to `level`=0 and the `release` pulse.
- `long_press` fires `LP_TICKS` cycles after the cycle in which `press` was high.
- A glitch shorter than `DB_TICKS` cycles, as seen at `s2`, produces no output change.
- Reset asserted mid-operation: on the next edge all state, counters and outputs return to reset values. No `release` pulse is emitted.
- Button held through the deassertion of reset: treated as a fresh press. `press` fires `DB_TICKS`+3 edges after the first edge with `reset`=0.

## Structure
- `debounce_pkg`: `state_t` enum (RELEASED, WAIT_PRESS, PRESSED, WAIT_RELEASE) and a `ms_to_ticks(clk_freq, ms)` function.
- Sub-module `sync_2ff`: the 2-flop synchronizer with synchronous reset, reusable for other board inputs.
- `button_debounce` holds the FSM, both counters and the output registers. Parameter legality is checked with elaboration-time assertions.

## Test plan
All scenarios use `CLK_FREQ`=10_000, `DEBOUNCE_MS`=1 (`DB_TICKS`=10) and `LONG_PRESS_MS`=5 (`LP_TICKS`=50).

1. Clean press held 20 cycles, then clean release → `press` one cycle at 13 edges after the rise, `level` high. `release` one cycle at 13 edges after the fall. No `long_press`.
2. Bounce: `btn_in` toggles 1/0 with a period of 6 cycles for 40 cycles, then 0 → `level` stays 0, no pulses.
3. Hold for 100 cycles → `press` then `long_press` exactly 50 cycles later, once only, then `release` after the fall.
4. During a hold, 4-cycle low glitches at cycles 20 and 40 → no `release`. `long_press` still fires 50 cycles after `press`.
5. `reset` pulsed for 1 cycle while `level`=1, button still held → all outputs 0 on the next edge with no `release`. `press` fires 13 edges after `reset` falls.
6. Release at cycle 30 of a hold, then re-press → only one `press`/`release` pair per press and no `long_press`. The counter is cleared: a second hold yields `long_press` 50 cycles after its own `press`.
